// File: rtl/huff_pkg.sv
// huff_pkg: shared widths, controller state encoding and the reference code table
// used by decoder models around huff_stream_ctrl.
package huff_pkg;
    localparam int MAX_LEN   = 6;
    localparam int SYM_W     = 4;
    localparam int LEN_W     = 4;
    localparam int NUM_CODES = 5;

    typedef enum logic [2:0] {IDLE, FILL, REQ, OUT, DONE, ERR} state_t;

    typedef struct packed {
        logic [MAX_LEN-1:0] bits;
        logic [LEN_W-1:0]   len;
        logic [SYM_W-1:0]   sym;
    } code_t;

    // Codes are left-aligned in a MAX_LEN field, zero-padded below their length.
    localparam code_t [NUM_CODES-1:0] CODE_TABLE = {
        code_t'{6'b011100, 4'd4, 4'd9},
        code_t'{6'b011000, 4'd6, 4'd3},
        code_t'{6'b010100, 4'd4, 4'd2},
        code_t'{6'b010000, 4'd4, 4'd1},
        code_t'{6'b100000, 4'd1, 4'd0}
    };
endpackage

// File: rtl/huff_bitbuf.sv
// huff_bitbuf: left-aligned bit buffer; consumes pop_len bits from the top and
// appends a word directly below the surviving valid bits in the same cycle.
module huff_bitbuf
    import huff_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 64,
    parameter int BC_W   = $clog2(BUF_W + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               push,
    input  logic [WORD_W-1:0]  push_data,
    input  logic               pop,
    input  logic [LEN_W-1:0]   pop_len,
    output logic [MAX_LEN-1:0] window,
    output logic [BC_W-1:0]    bit_cnt
);
    logic [BUF_W-1:0] buf_q, buf_d, shifted;
    logic [BC_W-1:0]  cnt_q, cnt_d, kept;

    // Bits below the valid region are always zero, so the window pads with zeros.
    always_comb begin
        kept    = cnt_q - (pop ? BC_W'(pop_len) : '0);
        shifted = pop ? buf_q << pop_len : buf_q;
        buf_d   = clr ? '0 : push ? shifted | ({push_data, {(BUF_W-WORD_W){1'b0}}} >> kept) : shifted;
        cnt_d   = clr ? '0 : push ? kept + BC_W'(WORD_W) : kept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign window  = buf_q[BUF_W-1 -: MAX_LEN];
    assign bit_cnt = cnt_q;
endmodule

// File: rtl/huff_stream_ctrl.sv
// huff_stream_ctrl: feeds a Huffman decoder core from a packed word stream and
// forwards decoded symbols downstream, counting them and flagging done/error.
module huff_stream_ctrl
    import huff_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 64,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [CNT_W-1:0]   num_symbols,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [MAX_LEN-1:0] dec_window,
    output logic               dec_req,
    input  logic               dec_ack,
    input  logic [SYM_W-1:0]   dec_sym,
    input  logic [LEN_W-1:0]   dec_len,
    output logic [SYM_W-1:0]   sym_data,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [CNT_W-1:0]   sym_count
);
    localparam int BC_W = $clog2(BUF_W + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, num_d, cnt_q, cnt_d;
    logic [SYM_W-1:0] sym_q, sym_d;
    logic             last_q, last_d;
    logic [BC_W-1:0]  bit_cnt;
    logic             go, kill, bad_len, push, pop, clr;

    huff_bitbuf #(.WORD_W(WORD_W), .BUF_W(BUF_W), .BC_W(BC_W)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_len   (dec_len),
        .window    (dec_window),
        .bit_cnt   (bit_cnt)
    );

    always_comb begin
        busy      = state_q inside {FILL, REQ, OUT};
        in_ready  = busy && !last_q && bit_cnt <= BC_W'(BUF_W - WORD_W);
        dec_req   = state_q == REQ;
        sym_valid = state_q == OUT;
        done      = state_q == DONE;
        error     = state_q == ERR;
        go        = start && (state_q == IDLE || state_q == ERR);
        kill      = abort && busy;
        bad_len   = dec_len == '0 || dec_len > LEN_W'(MAX_LEN) || BC_W'(dec_len) > bit_cnt;
        push      = in_valid && in_ready;
        pop       = dec_req && dec_ack && !bad_len && !kill;
        clr       = go || kill || done;
        last_d    = !clr && (last_q || (push && in_last));
        num_d     = go ? num_symbols : num_q;
        sym_d     = pop ? dec_sym : sym_q;
        cnt_d     = (go || kill) ? '0 : cnt_q + CNT_W'(sym_valid && sym_ready);
        state_d   = state_q;
        // abort outranks any decoder or downstream handshake in the same cycle
        if (go)
            state_d = num_symbols == '0 ? DONE : FILL;
        else if (kill)
            state_d = IDLE;
        else
            case (state_q)
                FILL:    state_d = (last_q && bit_cnt == '0) ? ERR :
                                   (bit_cnt >= BC_W'(MAX_LEN) || last_q) ? REQ : FILL;
                REQ:     state_d = !dec_ack ? REQ : bad_len ? ERR : OUT;
                OUT:     state_d = !sym_ready ? OUT : (cnt_d == num_q) ? DONE : FILL;
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            cnt_q   <= '0;
            sym_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            last_q  <= last_d;
        end
    end

    assign sym_data  = sym_q;
    assign sym_count = cnt_q;
endmodule

// File: tb/tb_huff_stream_ctrl.sv
// tb_huff_stream_ctrl: directed scenarios for huff_stream_ctrl with a table-driven
// decoder model, a word source queue and a symbol sink.
module tb_huff_stream_ctrl;
    import huff_pkg::*;

    logic        clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
    logic [15:0] num_symbols = '0;
    logic [31:0] in_data;
    logic        in_valid, in_last, in_ready;
    logic [5:0]  dec_window;
    logic        dec_req, dec_ack;
    logic [3:0]  dec_sym, dec_len, sym_data;
    logic        sym_valid, sym_ready, busy, done, error;
    logic [15:0] sym_count;

    int          checks = 0, fails = 0, n_done = 0;
    logic [32:0] words[$];
    logic [3:0]  got[$];
    bit          sink_en = 1'b1, dec_en = 1'b1, take;

    huff_stream_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_symbols(num_symbols),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .dec_window(dec_window), .dec_req(dec_req), .dec_ack(dec_ack), .dec_sym(dec_sym),
        .dec_len(dec_len), .sym_data(sym_data), .sym_valid(sym_valid), .sym_ready(sym_ready),
        .busy(busy), .done(done), .error(error), .sym_count(sym_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] decode(input logic [5:0] w);
        logic [5:0] m;
        for (int i = 0; i < NUM_CODES; i++) begin
            m = ~(6'b111111 >> CODE_TABLE[i].len);
            if ((w & m) == CODE_TABLE[i].bits) return {CODE_TABLE[i].len, CODE_TABLE[i].sym};
        end
        return 8'h00;
    endfunction

    initial begin
        dec_ack = 1'b0; dec_sym = '0; dec_len = '0;
        forever begin
            @(negedge clk);
            if (dec_en && dec_req && !dec_ack) begin
                dec_ack = 1'b1;
                {dec_len, dec_sym} = decode(dec_window);
            end else dec_ack = 1'b0;
        end
    end

    initial begin
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; take = 1'b0;
        forever begin
            @(negedge clk);
            if (take && words.size() > 0) void'(words.pop_front());
            if (words.size() > 0) begin
                {in_last, in_data} = words[0];
                in_valid = 1'b1;
            end else in_valid = 1'b0;
            take = in_valid && in_ready;
        end
    end

    initial begin
        sym_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (done) n_done++;
            if (sink_en && sym_valid) begin
                sym_ready = 1'b1;
                got.push_back(sym_data);
            end else sym_ready = 1'b0;
        end
    end

    task automatic begin_block(input logic [15:0] n);
        got.delete();
        @(negedge clk);
        num_symbols = n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sig(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            case (sel)
                0:       ok = done;
                1:       ok = dec_req;
                2:       ok = sym_valid;
                3:       ok = error;
                default: ok = dec_req && sym_count == 16'd1;
            endcase
            if (!ok) @(negedge clk);
        end
    endtask

    task automatic test_reset;
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, dec_window, dec_req, sym_data, sym_valid, busy, done, error, sym_count} !== 32'd0) begin
            fails++; $display("FAIL reset_outputs: got busy=%b err=%b cnt=%0d window=%b, expected all zero", busy, error, sym_count, dec_window);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero;
        begin_block(16'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL zero_done: got done=%b busy=%b expected done=1 busy=0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sym_count !== 16'd0) begin
            fails++; $display("FAIL zero_after: got done=%b cnt=%0d expected 0 0", done, sym_count);
        end
    endtask

    task automatic test_basic;
        logic [3:0] exp_s[3] = '{4'd0, 4'd1, 4'd2};
        bit ok;
        words.push_back({1'b0, 32'hA280_0000});
        begin_block(16'd3);
        checks++;
        if (busy !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", busy); end
        wait_sig(0, 200, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL basic_done: got no done pulse expected one"); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_s[i]) begin
                fails++; $display("FAIL basic_sym%0d: got %0d (n=%0d) expected %0d", i, i < got.size() ? got[i] : 4'hx, got.size(), exp_s[i]);
            end
        end
        checks++;
        if (sym_count !== 16'd3 || busy !== 1'b0) begin
            fails++; $display("FAIL basic_count: got cnt=%0d busy=%b expected cnt=3 busy=0", sym_count, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin fails++; $display("FAIL basic_pulse: got done=%b expected 0", done); end
    endtask

    task automatic test_boundary;
        logic [3:0] exp_s[10] = '{4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd3};
        bit ok;
        words.push_back({1'b0, 32'h5555_555D});
        words.push_back({1'b0, 32'h8000_0000});
        begin_block(16'd10);
        wait_sig(0, 400, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL bound_done: got no done pulse expected one"); end
        checks++;
        if (got.size() != 10) begin fails++; $display("FAIL bound_n: got %0d symbols expected 10", got.size()); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (i >= got.size() || got[i] !== exp_s[i]) begin
                fails++; $display("FAIL bound_sym%0d: got %0d expected %0d", i, i < got.size() ? got[i] : 4'hx, exp_s[i]);
            end
        end
        checks++;
        if (sym_count !== 16'd10) begin fails++; $display("FAIL bound_count: got %0d expected 10", sym_count); end
    endtask

    task automatic test_backpressure;
        bit ok;
        sink_en = 1'b0;
        words.push_back({1'b0, 32'h4000_0000});
        begin_block(16'd1);
        wait_sig(2, 50, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL bp_valid: got no sym_valid expected one"); end
        num_symbols = 16'd9;
        start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (sym_valid !== 1'b1 || sym_data !== 4'd1 || dec_req !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d: got valid=%b data=%0d req=%b expected 1 1 0", i, sym_valid, sym_data, dec_req);
            end
        end
        sink_en = 1'b1;
        wait_sig(0, 50, ok);
        checks++;
        if (!ok || sym_count !== 16'd1) begin
            fails++; $display("FAIL bp_done: got done_seen=%b cnt=%0d expected 1 1", ok, sym_count);
        end
    endtask

    task automatic test_bad_len;
        bit ok;
        words.push_back({1'b0, 32'h0000_0000});
        begin_block(16'd2);
        wait_sig(1, 50, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL bad_req: got no dec_req expected one"); end
        @(negedge clk);
        checks++;
        if ({error, busy, dec_req, in_ready, sym_valid} !== 5'b10000) begin
            fails++; $display("FAIL bad_err: got err=%b busy=%b req=%b rdy=%b val=%b expected 1 0 0 0 0", error, busy, dec_req, in_ready, sym_valid);
        end
        words.push_back({1'b0, 32'h8000_0000});
        begin_block(16'd1);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL bad_restart: got err=%b busy=%b expected 0 1", error, busy);
        end
        wait_sig(0, 50, ok);
        checks++;
        if (!ok || got.size() != 1 || got[0] !== 4'd0) begin
            fails++; $display("FAIL bad_recover: got done_seen=%b n=%0d expected done and one symbol 0", ok, got.size());
        end
    endtask

    task automatic test_underflow;
        bit ok;
        int d0;
        d0 = n_done;
        words.push_back({1'b1, 32'hFFFF_FFFF});
        begin_block(16'd40);
        wait_sig(3, 400, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL under_err: got no error expected error"); end
        checks++;
        if (sym_count !== 16'd32 || got.size() != 32 || n_done != d0) begin
            fails++; $display("FAIL under_count: got cnt=%0d n=%0d dones=%0d expected 32 32 0", sym_count, got.size(), n_done - d0);
        end
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL under_idle: got busy=%b rdy=%b expected 0 0", busy, in_ready);
        end
        words.push_back({1'b1, 32'hFFFF_FFFD});
        begin_block(16'd40);
        wait_sig(3, 400, ok);
        checks++;
        if (!ok || sym_count !== 16'd30) begin
            fails++; $display("FAIL under_short: got err=%b cnt=%0d expected 1 30", ok, sym_count);
        end
    endtask

    task automatic test_abort;
        bit ok;
        int d0;
        d0 = n_done;
        words.push_back({1'b0, 32'hC000_0000});
        begin_block(16'd5);
        wait_sig(4, 100, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL abort_reach: got no second dec_req expected one"); end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({busy, dec_req, sym_valid, in_ready, done} !== 5'b0 || sym_count !== 16'd0 || dec_window !== 6'd0) begin
            fails++; $display("FAIL abort_idle: got busy=%b req=%b val=%b cnt=%0d win=%b expected all 0", busy, dec_req, sym_valid, sym_count, dec_window);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_done != d0) begin
            fails++; $display("FAIL abort_nodone: got busy=%b dones=%0d expected 0 0", busy, n_done - d0);
        end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int d0;
        dec_en = 1'b0;
        words.push_back({1'b0, 32'h8000_0000});
        begin_block(16'd1);
        wait_sig(1, 50, ok);
        checks++;
        if (!ok) begin fails++; $display("FAIL rstmid_req: got no dec_req expected one"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, dec_window, dec_req, sym_data, sym_valid, busy, done, error, sym_count} !== 32'd0) begin
            fails++; $display("FAIL rstmid_outputs: got busy=%b req=%b win=%b expected all zero", busy, dec_req, dec_window);
        end
        d0 = n_done;
        @(negedge clk);
        rst = 1'b0;
        dec_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || n_done != d0) begin
            fails++; $display("FAIL rstmid_quiet: got busy=%b dones=%0d expected 0 0", busy, n_done - d0);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_basic();
        test_boundary();
        test_backpressure();
        test_bad_len();
        test_underflow();
        test_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end
endmodule
